// File: rtl/program_sequencer_pkg.sv
// rtl/program_sequencer_pkg.sv - shared FSM state and hl_sel encodings for program_sequencer
package program_sequencer_pkg;

  typedef enum logic [2:0] {
    S_IDLE   = 3'd0,
    S_CLR    = 3'd1,
    S_INCR   = 3'd2,
    S_WR     = 3'd3,
    S_BRANCH = 3'd4,
    S_CALL   = 3'd5,
    S_RET    = 3'd6,
    S_ACK    = 3'd7
  } state_t;

  localparam logic [1:0] HL_FULL = 2'b00;
  localparam logic [1:0] HL_LOW  = 2'b01;
  localparam logic [1:0] HL_HIGH = 2'b10;
  localparam logic [1:0] HL_NONE = 2'b11;

endpackage

// File: rtl/program_sequencer_ret_stack.sv
// rtl/program_sequencer_ret_stack.sv - LIFO return stack with registered full/empty status
module ret_stack
  import program_sequencer_pkg::*;
#(
  parameter int PA_DATA  = 32,
  parameter int PA_DEPTH = 8
) (
  input  logic               clk,
  input  logic               rst,
  input  logic               push,
  input  logic               pop,
  input  logic [PA_DATA-1:0] din,
  output logic [PA_DATA-1:0] top,
  output logic               full,
  output logic               empty
);

  localparam int AW = $clog2(PA_DEPTH);
  localparam logic [AW:0]   CNT_ONE = (AW+1)'(1);
  localparam logic [AW:0]   CNT_MAX = (AW+1)'(PA_DEPTH);
  localparam logic [AW-1:0] IDX_ONE = AW'(1);

  logic [PA_DATA-1:0] mem [PA_DEPTH];
  logic [AW:0]        count;
  logic [AW-1:0]      wr_idx;
  logic [AW-1:0]      top_idx;

  assign wr_idx  = count[AW-1:0];
  assign top_idx = count[AW-1:0] - IDX_ONE;
  assign top     = mem[top_idx];

  // Storage is not reset; only the occupancy count and flags are.
  always_ff @(posedge clk) begin
    if (push && !full && !rst) begin
      mem[wr_idx] <= din;
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      count <= '0;
      full  <= 1'b0;
      empty <= 1'b1;
    end else if (push && !full) begin
      count <= count + CNT_ONE;
      full  <= (count + CNT_ONE) == CNT_MAX;
      empty <= 1'b0;
    end else if (pop && !empty) begin
      count <= count - CNT_ONE;
      full  <= 1'b0;
      empty <= count == CNT_ONE;
    end
  end

endmodule

// File: rtl/program_sequencer.sv
// rtl/program_sequencer.sv - program counter sequencer with call/return stack and acked operations
module program_sequencer
  import program_sequencer_pkg::*;
#(
  parameter int PA_DATA    = 32,
  parameter int PA_HL      = 2,
  parameter int PA_STEP    = 1,
  parameter int PA_DEPTH   = 8,
  parameter int PA_RST_VEC = 0
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [PA_DATA-1:0] data_in,
  input  logic [PA_HL-1:0]   hl_sel,
  input  logic               reg_clr,
  input  logic               pc_ret,
  input  logic               pc_call,
  input  logic               pc_branch,
  input  logic               pc_incr,
  input  logic               reg_wr,
  output logic [PA_DATA-1:0] data_out,
  output logic               reg_wr_ack,
  output logic               stk_err,
  output logic               stk_full,
  output logic               stk_empty
);

  localparam logic [PA_DATA-1:0] STEP_C = PA_DATA'(PA_STEP);
  localparam logic [PA_DATA-1:0] RST_C  = PA_DATA'(PA_RST_VEC);

  state_t             state;
  logic [PA_DATA-1:0] op_data;
  logic [PA_HL-1:0]   op_hl;
  logic               err_pend;
  logic               stk_push;
  logic               stk_pop;
  logic [PA_DATA-1:0] stk_top;

  // Stack control comes from registered state only, never straight from strobes.
  assign stk_push = (state == S_CALL) && !stk_full;
  assign stk_pop  = (state == S_RET) && !stk_empty;

  ret_stack #(
    .PA_DATA  (PA_DATA),
    .PA_DEPTH (PA_DEPTH)
  ) u_ret_stack (
    .clk   (clk),
    .rst   (rst),
    .push  (stk_push),
    .pop   (stk_pop),
    .din   (data_out + STEP_C),
    .top   (stk_top),
    .full  (stk_full),
    .empty (stk_empty)
  );

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= S_IDLE;
      data_out   <= RST_C;
      reg_wr_ack <= 1'b0;
      stk_err    <= 1'b0;
      err_pend   <= 1'b0;
      op_data    <= '0;
      op_hl      <= '0;
    end else begin
      reg_wr_ack <= 1'b0;
      stk_err    <= 1'b0;
      case (state)
        S_IDLE: begin
          // Operand is latched every idle cycle; the accepting edge holds it.
          op_data  <= data_in;
          op_hl    <= hl_sel;
          err_pend <= 1'b0;
          if (reg_clr)        state <= S_CLR;
          else if (pc_ret)    state <= S_RET;
          else if (pc_call)   state <= S_CALL;
          else if (pc_branch) state <= S_BRANCH;
          else if (pc_incr)   state <= S_INCR;
          else if (reg_wr)    state <= S_WR;
        end
        S_CLR: begin
          data_out <= RST_C;
          state    <= S_ACK;
        end
        S_INCR: begin
          data_out <= data_out + STEP_C;
          state    <= S_ACK;
        end
        S_BRANCH: begin
          data_out <= data_out + op_data;
          state    <= S_ACK;
        end
        S_WR: begin
          case (op_hl[1:0])
            HL_FULL: data_out <= op_data;
            HL_LOW:  data_out[15:0] <= op_data[15:0];
            HL_HIGH: data_out[PA_DATA-1:16] <= op_data[PA_DATA-1:16];
            default: data_out <= data_out;
          endcase
          state <= S_ACK;
        end
        S_CALL: begin
          if (!stk_full) data_out <= op_data;
          else           err_pend <= 1'b1;
          state <= S_ACK;
        end
        S_RET: begin
          if (!stk_empty) data_out <= stk_top;
          else            err_pend <= 1'b1;
          state <= S_ACK;
        end
        S_ACK: begin
          reg_wr_ack <= 1'b1;
          stk_err    <= err_pend;
          state      <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_program_sequencer.sv
// tb/tb_program_sequencer.sv - randomized self-checking bench for program_sequencer against a stack/PC model
module tb_program_sequencer;

  localparam logic [5:0] ST_CLR  = 6'b100000;
  localparam logic [5:0] ST_RET  = 6'b010000;
  localparam logic [5:0] ST_CALL = 6'b001000;
  localparam logic [5:0] ST_BR   = 6'b000100;
  localparam logic [5:0] ST_INC  = 6'b000010;
  localparam logic [5:0] ST_WR   = 6'b000001;

  logic        clk = 1'b0;
  logic        rst;
  logic [31:0] data_in;
  logic [1:0]  hl_sel;
  logic        reg_clr, pc_ret, pc_call, pc_branch, pc_incr, reg_wr;

  logic [31:0] dout_a, dout_b;
  logic        ack_a, ack_b, err_a, err_b, full_a, full_b, empty_a, empty_b;

  always #5 clk = ~clk;

  program_sequencer #(.PA_DATA(32), .PA_HL(2), .PA_STEP(4), .PA_DEPTH(8), .PA_RST_VEC(0)) u_a (
    .clk(clk), .rst(rst), .data_in(data_in), .hl_sel(hl_sel),
    .reg_clr(reg_clr), .pc_ret(pc_ret), .pc_call(pc_call), .pc_branch(pc_branch),
    .pc_incr(pc_incr), .reg_wr(reg_wr),
    .data_out(dout_a), .reg_wr_ack(ack_a), .stk_err(err_a), .stk_full(full_a), .stk_empty(empty_a)
  );

  program_sequencer #(.PA_DATA(32), .PA_HL(2), .PA_STEP(1), .PA_DEPTH(2), .PA_RST_VEC(0)) u_b (
    .clk(clk), .rst(rst), .data_in(data_in), .hl_sel(hl_sel),
    .reg_clr(reg_clr), .pc_ret(pc_ret), .pc_call(pc_call), .pc_branch(pc_branch),
    .pc_incr(pc_incr), .reg_wr(reg_wr),
    .data_out(dout_b), .reg_wr_ack(ack_b), .stk_err(err_b), .stk_full(full_b), .stk_empty(empty_b)
  );

  int n_pass   = 0;
  int n_checks = 0;

  logic [31:0] m_pc  [2];
  logic [31:0] m_stk [2][8];
  int          m_sp  [2];
  logic        m_err [2];
  int          m_step  [2] = '{4, 1};
  int          m_depth [2] = '{8, 2};

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    n_checks++;
    if (obs === exp) n_pass++;
    else $display("FAIL %s: got %h expected %h", tag, obs, exp);
  endtask

  task automatic model_reset();
    for (int i = 0; i < 2; i++) begin
      m_pc[i]  = 32'h0;
      m_sp[i]  = 0;
      m_err[i] = 1'b0;
    end
  endtask

  task automatic model_apply(input logic [5:0] st, input logic [31:0] d, input logic [1:0] hl);
    for (int i = 0; i < 2; i++) begin
      m_err[i] = 1'b0;
      if (st[5]) begin
        m_pc[i] = 32'h0;
      end else if (st[4]) begin
        if (m_sp[i] == 0) m_err[i] = 1'b1;
        else begin
          m_sp[i] = m_sp[i] - 1;
          m_pc[i] = m_stk[i][m_sp[i]];
        end
      end else if (st[3]) begin
        if (m_sp[i] == m_depth[i]) m_err[i] = 1'b1;
        else begin
          m_stk[i][m_sp[i]] = m_pc[i] + 32'(m_step[i]);
          m_sp[i] = m_sp[i] + 1;
          m_pc[i] = d;
        end
      end else if (st[2]) begin
        m_pc[i] = m_pc[i] + d;
      end else if (st[1]) begin
        m_pc[i] = m_pc[i] + 32'(m_step[i]);
      end else if (st[0]) begin
        case (hl)
          2'b00:   m_pc[i] = d;
          2'b01:   m_pc[i] = {m_pc[i][31:16], d[15:0]};
          2'b10:   m_pc[i] = {d[31:16], m_pc[i][15:0]};
          default: m_pc[i] = m_pc[i];
        endcase
      end
    end
  endtask

  task automatic check_outputs(input string tag, input logic exp_ack);
    for (int i = 0; i < 2; i++) begin
      check($sformatf("%s.pc[%0d]", tag, i), (i == 0) ? dout_a : dout_b, m_pc[i]);
      check($sformatf("%s.ack[%0d]", tag, i), {31'b0, (i == 0) ? ack_a : ack_b}, {31'b0, exp_ack});
      check($sformatf("%s.err[%0d]", tag, i), {31'b0, (i == 0) ? err_a : err_b},
            {31'b0, exp_ack & m_err[i]});
      check($sformatf("%s.full[%0d]", tag, i), {31'b0, (i == 0) ? full_a : full_b},
            {31'b0, m_sp[i] == m_depth[i]});
      check($sformatf("%s.empty[%0d]", tag, i), {31'b0, (i == 0) ? empty_a : empty_b},
            {31'b0, m_sp[i] == 0});
    end
  endtask

  // Strobes stay high through the ACK edge, and operands are scrambled after acceptance.
  task automatic do_op(input logic [5:0] st, input logic [31:0] d, input logic [1:0] hl);
    {reg_clr, pc_ret, pc_call, pc_branch, pc_incr, reg_wr} = st;
    data_in = d;
    hl_sel  = hl;
    model_apply(st, d, hl);
    @(posedge clk); #1;
    data_in = $urandom;
    hl_sel  = 2'($urandom_range(0, 3));
    @(posedge clk); #1;
    check_outputs("exec", 1'b0);
    @(posedge clk); #1;
    check_outputs("ack", 1'b1);
    {reg_clr, pc_ret, pc_call, pc_branch, pc_incr, reg_wr} = 6'b0;
    @(posedge clk); #1;
    check_outputs("idle", 1'b0);
  endtask

  initial begin
    logic [5:0] st;
    rst = 1'b1;
    data_in = 32'h0;
    hl_sel = 2'b00;
    {reg_clr, pc_ret, pc_call, pc_branch, pc_incr, reg_wr} = 6'b0;
    model_reset();
    repeat (2) @(posedge clk);
    #1;
    check_outputs("reset", 1'b0);
    rst = 1'b0;

    repeat (3) do_op(ST_INC, 32'h0, 2'b00);
    check("incr3_a", dout_a, 32'd12);
    check("incr3_b", dout_b, 32'd3);

    do_op(ST_WR, 32'h0000_1000, 2'b00);
    do_op(ST_BR, 32'hFFFF_FFF0, 2'b00);
    check("branch_neg", dout_a, 32'h0000_0FF0);

    do_op(ST_WR, 32'hFFFF_FFFF, 2'b00);
    do_op(ST_INC, 32'h0, 2'b00);
    check("incr_wrap", dout_b, 32'h0);

    do_op(ST_WR, 32'h1234_5678, 2'b00);
    do_op(ST_WR, 32'hAAAA_5555, 2'b01);
    check("wr_low", dout_a, 32'h1234_5555);
    do_op(ST_WR, 32'hDEAD_BEEF, 2'b11);
    check("wr_none", dout_a, 32'h1234_5555);

    do_op(ST_WR, 32'h10, 2'b00);
    do_op(ST_CALL, 32'h20, 2'b00);
    do_op(ST_CALL, 32'h40, 2'b00);
    check("call_full", {31'b0, full_b}, 32'h1);
    do_op(ST_CALL, 32'h80, 2'b00);
    check("call_ovf_pc", dout_b, 32'h40);
    do_op(ST_RET, 32'h0, 2'b00);
    check("ret1", dout_b, 32'h21);
    do_op(ST_RET, 32'h0, 2'b00);
    check("ret2", dout_b, 32'h11);
    do_op(ST_RET, 32'h0, 2'b00);
    check("ret_unf_empty", {31'b0, empty_b}, 32'h1);

    do_op(ST_WR, 32'h50, 2'b00);
    do_op(ST_CALL, 32'h60, 2'b00);
    do_op(ST_CLR | ST_CALL | ST_INC, 32'h70, 2'b00);
    check("clr_wins", dout_b, 32'h0);
    check("clr_stack_kept", {31'b0, empty_b}, 32'h0);

    pc_call = 1'b1;
    data_in = 32'h99;
    @(posedge clk); #1;
    rst = 1'b1;
    pc_call = 1'b0;
    @(posedge clk); #1;
    rst = 1'b0;
    model_reset();
    repeat (3) begin
      @(posedge clk); #1;
      check_outputs("rst_abort", 1'b0);
    end

    for (int n = 0; n < 250; n++) begin
      if ($urandom_range(0, 3) != 0) st = 6'(1 << $urandom_range(0, 5));
      else st = 6'($urandom_range(1, 63));
      do_op(st, $urandom, 2'($urandom_range(0, 3)));
    end

    $display("%0d/%0d checks passed", n_pass, n_checks);
    $finish;
  end

endmodule

// File: doc/program_sequencer.md
PROGRAM_SEQUENCER -- requirements
Module: program_sequencer

Interface
REQ-001 SHALL have parameter PA_DATA, default 32: width of the PC and data_in.
REQ-002 SHALL have parameter PA_HL, default 2: width of hl_sel.
REQ-003 SHALL have parameter PA_STEP, default 1: sequential increment amount.
REQ-004 SHALL have parameter PA_DEPTH, default 8: return-stack depth, a power of two and at least 2.
REQ-005 SHALL have parameter PA_RST_VEC, default 0: PC value after reset and after clear.
REQ-006 SHALL have port clk, input, 1 bit: the single clock; all logic is on its rising edge.
REQ-007 SHALL have port rst, input, 1 bit: reset, synchronous and active-high.
REQ-008 SHALL have port data_in, input, PA_DATA bits: write value, jump target or signed branch offset.
REQ-009 SHALL have port hl_sel, input, PA_HL bits: write select (00 full word, 01 low half, 10 high half, 11 no change).
REQ-010 SHALL have strobe inputs of 1 bit each: reg_clr, pc_ret, pc_call, pc_branch, pc_incr, reg_wr.
REQ-011 SHALL have port data_out, output, PA_DATA bits: the current PC, registered.
REQ-012 SHALL have port reg_wr_ack, output, 1 bit: registered one-cycle completion pulse.
REQ-013 SHALL have port stk_err, output, 1 bit: registered pulse, coincident with reg_wr_ack, on stack overflow or underflow.
REQ-014 SHALL have ports stk_full and stk_empty, outputs, 1 bit each: registered return-stack status.

Function
REQ-015 SHALL use FSM states IDLE, CLR, INCR, WR, BRANCH, CALL, RET and ACK.
REQ-016 SHALL sample strobes only in IDLE; strobes asserted in any other state are ignored and are not queued.
REQ-017 SHALL resolve simultaneous strobes by priority: reg_clr > pc_ret > pc_call > pc_branch > pc_incr > reg_wr.
REQ-018 SHALL, on acceptance, capture data_in and hl_sel into an operand register; later changes to these inputs have no effect.
REQ-019 SHALL meet this timing: strobe sampled at edge k gives an operation state at edge k; data_out updates at edge k+1 and the state becomes ACK; reg_wr_ack is high from edge k+2 to edge k+3 and the state is IDLE from edge k+2.
REQ-020 SHALL, in CLR, load PA_RST_VEC into data_out, with no increment, and leave the stack unchanged.
REQ-021 SHALL, in INCR, set data_out to (data_out + PA_STEP) mod 2^PA_DATA.
REQ-022 SHALL, in BRANCH, set data_out to (data_out + signed operand) mod 2^PA_DATA.
REQ-023 SHALL, in WR, apply hl_sel: 00 loads the full word, 01 loads [15:0], 10 loads [PA_DATA-1:16], 11 leaves data_out unchanged but still acks.
REQ-024 SHALL, in CALL when the stack is not full, push (data_out + PA_STEP) mod 2^PA_DATA and load the operand into data_out.
REQ-025 SHALL, in CALL when the stack is full, skip the push, leave the PC unchanged and pulse stk_err.
REQ-026 SHALL, in RET when the stack is not empty, pop the top entry into data_out.
REQ-027 SHALL, in RET when the stack is empty, leave the PC unchanged and pulse stk_err.
REQ-028 SHALL update stk_full and stk_empty in the same edge as the push or pop.

Reset
REQ-029 SHALL, while rst is high at a clock edge, set data_out=PA_RST_VEC, reg_wr_ack=0, stk_err=0, stack count=0, stk_empty=1, stk_full=0 and state=IDLE.
REQ-030 SHALL let reset abort any in-flight operation, which produces no ack, and SHALL leave stack storage contents don't-care.

Structure
REQ-031 SHALL place the FSM state encodings (3 bits) and the hl_sel encodings as constants in shared package program_sequencer_pkg.
REQ-032 SHALL implement the return stack as sub-module ret_stack (LIFO, PA_DATA wide, PA_DEPTH deep, push/pop/full/empty), with no combinational path from the strobes to the outputs.

Verification
REQ-033 SHALL cover reset then pc_incr three times with PA_STEP=4: data_out 0->4->8->12, one ack per operation, 4 cycles per operation.
REQ-034 SHALL cover data_out=0x00001000 and pc_branch with data_in=0xFFFFFFF0: data_out=0x00000FF0; and data_out=0xFFFFFFFF with pc_incr (step 1): data_out=0 (wrap).
REQ-035 SHALL cover reg_wr with hl_sel=01, data_in=0xAAAA5555 and data_out=0x12345678: result 0x12345555; and hl_sel=11: unchanged, ack present.
REQ-036 SHALL cover PA_DEPTH=2 with calls at PC 0x10 and 0x20 (stk_full=1), then a third call: stk_err=1 and PC unchanged; then two returns give 0x21 then 0x11, and a third return gives stk_err=1 with stk_empty=1.
REQ-037 SHALL cover reg_clr, pc_call and pc_incr asserted together: clear wins, data_out=PA_RST_VEC and the stack is unchanged; a strobe held during ACK is not executed twice.
REQ-038 SHALL cover rst asserted in the cycle after a call is accepted: no ack, data_out=PA_RST_VEC and stk_empty=1.
